pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, stall/flush, forwarding and multi-cycle control for a 5-stage pipeline
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_md_op,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regWrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regWrite,
  input  logic             md_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_start,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       load_use;

  assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;
    state_nxt    = state;
    if (resetn) begin
      if (state == RUN) begin
        if (ex_md_op) begin
          // whole pipe freezes; EX/MEM gets bubbles until the unit answers
          md_start     = 1'b1;
          ex_mem_flush = 1'b1;
          state_nxt    = MD_WAIT;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end else begin
        if (md_done) begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          state_nxt = RUN;
        end else begin
          ex_mem_en    = 1'b1;
          ex_mem_flush = 1'b1;
        end
      end
    end
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (resetn) begin
      if (mem_regWrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
        fwdA = 2'b10;
      else if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
        fwdA = 2'b01;
      if (mem_regWrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
        fwdB = 2'b10;
      else if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
        fwdB = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_en)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (if_id_flush)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_memRead, ex_md_op, ex_branch_taken;
  logic          mem_regWrite, wb_regWrite, md_done;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, md_start;
  logic [1:0]    fwdA, fwdB;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  int   m_stall = 0;
  int   m_flush = 0;
  logic m_wait  = 1'b0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_md_op(ex_md_op), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
    .md_done(md_done),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_start(md_start), .fwdA(fwdA), .fwdB(fwdB),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected control word {pc,ifid,idex,exmem, if_id_fl,id_ex_fl,ex_mem_fl, md_start}
  function automatic logic [7:0] ctl_model();
    logic hazard;
    hazard = ex_memRead && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!resetn)         return 8'b0000_0000;
    if (m_wait)          return md_done ? 8'b1111_0000 : 8'b0001_0010;
    if (ex_md_op)        return 8'b0000_0011;
    if (ex_branch_taken) return 8'b1111_1100;
    if (hazard)          return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (!resetn || rs == 0) return 2'b00;
    if (mem_regWrite && mem_rd == rs) return 2'b10;
    if (wb_regWrite && wb_rd == rs)   return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [7:0] e;
    e = ctl_model();
    chk("ctl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en,
                    if_id_flush, id_ex_flush, ex_mem_flush, md_start}), 32'(e));
    chk("fwdA", 32'(fwdA), 32'(fwd_model(ex_rs1)));
    chk("fwdB", 32'(fwdB), 32'(fwd_model(ex_rs2)));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall % (1 << CW)));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush % (1 << CW)));
    if (!resetn) begin
      m_wait  = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!e[7]) m_stall++;
      if (e[3])  m_flush++;
      m_wait = m_wait ? !md_done : ex_md_op;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_memRead = 0; ex_md_op = 0; ex_branch_taken = 0;
    mem_rd = 0; mem_regWrite = 0; wb_rd = 0; wb_regWrite = 0; md_done = 0;
  endtask

  typedef struct {
    logic [4:0] mrd; logic mwe; logic [4:0] wrd; logic wwe;
    logic [4:0] rs1; logic [4:0] rs2; logic [1:0] ea; logic [1:0] eb;
  } fwd_vec_t;

  fwd_vec_t fv[5] = '{
    '{5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 2'b10, 2'b10},
    '{5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 5'd3, 2'b01, 2'b00},
    '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00},
    '{5'd4, 1'b1, 5'd9, 1'b1, 5'd9, 5'd4, 2'b01, 2'b10},
    '{5'd3, 1'b1, 5'd3, 1'b0, 5'd2, 5'd3, 2'b00, 2'b10}
  };

  initial begin
    clear_in();
    resetn = 1'b0;
    tick(); tick();
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    resetn = 1'b1;
    tick();

    // load-use on rs1
    ex_memRead = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    #1;
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_if_id_en", 32'(if_id_en), 0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    clear_in();

    // rd = 0 never stalls
    ex_memRead = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    #1;
    chk("rd0_pc_en", 32'(pc_en), 1);
    chk("rd0_if_id_en", 32'(if_id_en), 1);
    tick();
    clear_in();
    ex_memRead = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 0;
    tick();
    id_uses_rs2 = 1;
    tick();
    chk("lu2_stall_cnt", 32'(stall_cnt), 2);
    clear_in();

    // branch beats load-use
    ex_memRead = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_branch_taken = 1;
    #1;
    chk("br_if_id_flush", 32'(if_id_flush), 1);
    chk("br_id_ex_flush", 32'(id_ex_flush), 1);
    chk("br_pc_en", 32'(pc_en), 1);
    tick();
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 2);
    clear_in();

    // multi-cycle op, done after 4 wait cycles
    ex_md_op = 1;
    #1;
    chk("md_start_pulse", 32'(md_start), 1);
    chk("md_pc_en", 32'(pc_en), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      ex_branch_taken = (i == 1);
      #1;
      chk("md_wait_start", 32'(md_start), 0);
      chk("md_wait_exmem", 32'({ex_mem_en, ex_mem_flush}), 32'b11);
      tick();
    end
    ex_branch_taken = 0;
    md_done = 1;
    #1;
    chk("md_done_pc_en", 32'(pc_en), 1);
    chk("md_done_exmem", 32'({ex_mem_en, ex_mem_flush, md_start}), 32'b100);
    tick();
    chk("md_stall_cnt", 32'(stall_cnt), 7);
    chk("md_flush_cnt", 32'(flush_cnt), 1);
    ex_md_op = 0;
    #1;
    chk("md_done_run_start", 32'(md_start), 0);
    chk("md_done_run_pc_en", 32'(pc_en), 1);
    tick();
    md_done = 0;

    // forwarding table
    foreach (fv[k]) begin
      mem_rd = fv[k].mrd; mem_regWrite = fv[k].mwe;
      wb_rd = fv[k].wrd; wb_regWrite = fv[k].wwe;
      ex_rs1 = fv[k].rs1; ex_rs2 = fv[k].rs2;
      #1;
      chk($sformatf("fwdA_vec%0d", k), 32'(fwdA), 32'(fv[k].ea));
      chk($sformatf("fwdB_vec%0d", k), 32'(fwdB), 32'(fv[k].eb));
      tick();
    end

    // reset during MD_WAIT
    mem_rd = 7; mem_regWrite = 1; ex_rs1 = 7;
    ex_md_op = 1;
    tick(); tick();
    resetn = 0;
    #1;
    chk("rst_wait_pc_en", 32'(pc_en), 0);
    chk("rst_wait_fwdA", 32'(fwdA), 0);
    tick();
    chk("rst_wait_stall", 32'(stall_cnt), 0);
    resetn = 1; ex_md_op = 0; md_done = 1;
    #1;
    chk("rst_rel_md_start", 32'(md_start), 0);
    chk("rst_rel_ctl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, ex_mem_flush}), 32'b11110);
    tick();
    clear_in();
    chk("rst_rel_flush", 32'(flush_cnt), 0);

    // stall counter wraps (4-bit instance)
    ex_memRead = 1; ex_rd = 12; id_rs2 = 12; id_uses_rs2 = 1;
    repeat (18) tick();
    chk("wrap_stall_cnt", 32'(stall_cnt), 2);
    clear_in();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
